icb_dma_master: RTL
===================

# icb_dma_master

ICB initiator that moves blocks of 32-bit words between system memory (over the E203 ICB bus) and the accelerator's local SRAM. It is the bus-master counterpart of the accelerator's ICB register/SRAM slave: software programs base addresses and length there, and the control logic pulses `start` here to fetch operands or write back results. It issues one ICB transaction at a time, single-word, full-mask.

## Interface
Parameters:
- `SRAM_AW`, 13: local SRAM word-address width.
- `LEN_W`, 13: transfer length width, in words.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `dir` in 1: 0 = memory→SRAM (read bus), 1 = SRAM→memory (write bus); sampled with `start`.
- `mem_base` in 32: byte address of first memory word; low 2 bits ignored (forced 0).
- `sram_base` in SRAM_AW: first SRAM word address.
- `len` in LEN_W: number of words.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky bus-error flag, cleared by next accepted `start`.
- `icb_cmd_valid` out 1, `icb_cmd_ready` in 1, `icb_cmd_read` out 1, `icb_cmd_addr` out 32, `icb_cmd_wdata` out 32, `icb_cmd_wmask` out 4.
- `icb_rsp_valid` in 1, `icb_rsp_ready` out 1, `icb_rsp_rdata` in 32, `icb_rsp_err` in 1.
- `sram_rd_en` out 1, `sram_rd_addr` out SRAM_AW, `sram_rd_data` in 32 (valid the cycle after `sram_rd_en`).
- `sram_wr_en` out 1, `sram_wr_addr` out SRAM_AW, `sram_wr_data` out 32.

## Operation
- States: IDLE, SRD, SWAIT, CMD, RSP, FIN.
- IDLE: on `start`, latch `dir`, `mem_base`, `sram_base`, `len`; clear `err`; idx←0. `len`==0 → FIN; else `dir`=0 → CMD, `dir`=1 → SRD.
- SRD (dir=1): `sram_rd_en`=1, `sram_rd_addr`=sram_base+idx → SWAIT.
- SWAIT: register `sram_rd_data` into the wdata holding register → CMD.
- CMD: `icb_cmd_valid`=1, `icb_cmd_read`=~dir, `icb_cmd_addr`=mem_base+4·idx, `icb_cmd_wmask`=4'hF, `icb_cmd_wdata`=held data (dir=1) else 0. Valid and all cmd fields stay stable until `icb_cmd_ready`; on handshake → RSP.
- RSP: `icb_rsp_ready`=1. On `icb_rsp_valid`:
  - `icb_rsp_err`=1: set `err`, no SRAM write → FIN (abort).
  - else if dir=0: `sram_wr_en`=1 for one cycle (registered, next cycle), addr sram_base+idx, data `icb_rsp_rdata`.
  - idx==len−1 → FIN; else idx++ and → CMD (dir=0) or SRD (dir=1).
- FIN: `done`=1 for exactly one cycle → IDLE.
- `start` outside IDLE ignored. `err` remains set through IDLE until next accepted `start`.
- Arithmetic: memory address wraps modulo 2^32; SRAM address wraps modulo 2^SRAM_AW; idx is LEN_W bits.
- Reset mid-transfer: state IDLE immediately; a pending ICB transaction is abandoned (system reset is common).

## Timing
- Reset values: all outputs 0 (`busy`, `done`, `err`, all cmd/rsp/SRAM strobes, addresses, data).
- `busy`=1 in every non-IDLE state, including FIN; low in IDLE.
- Zero-wait bus: dir=0 → 2 cycles/word (CMD, RSP); dir=1 → 4 cycles/word (SRD, SWAIT, CMD, RSP). `done` follows final RSP by 1 cycle.
- `len`=0: `done` in cycle after `start`, no ICB or SRAM activity.
- The final dir=0 SRAM write occurs in the same cycle as `done`.
- Only one outstanding ICB transaction; `icb_cmd_valid` never asserted in RSP.

## Structure
- Package `dma_pkg`: state enum `dma_state_e`, ICB widths (`ICB_AW`=32, `ICB_DW`=32), `WMASK_FULL`=4'hF.
- Single module; no sub-module. Address/idx counters and FSM live together.

## Test plan
- dir=0, mem_base=0x8000_0000, sram_base=0x10, len=4, bus returns 0xA0..0xA3, zero-wait → SRAM writes addr 0x10..0x13 data 0xA0..0xA3; cmd addrs 0x8000_0000..0x8000_000C; `done` at cycle 9 after start.
- dir=1, sram holds 0x11,0x22,0x33 at 0..2, len=3, mem_base=0x2000 → ICB writes 0x11@0x2000, 0x22@0x2004, 0x33@0x2008, wmask 4'hF, one `done`.
- Random `icb_cmd_ready`/`icb_rsp_valid` stalls (0–5 cycles) → cmd fields stable while stalled, data identical to zero-wait run.
- `icb_rsp_err` on word 2 of len=5 read → SRAM written only words 0–1, `err`=1, `done` pulse, `err` cleared on next `start`.
- len=0 → `done` one cycle after `start`, no strobes; `start` while busy → ignored.
- sram_base=0x1FFE, len=4 → SRAM addrs 0x1FFE,0x1FFF,0x0000,0x0001; `rst_n` low mid-RSP → all outputs 0, IDLE.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the ICB DMA master.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SRD   = 3'd1,
    S_SWAIT = 3'd2,
    S_CMD   = 3'd3,
    S_RSP   = 3'd4,
    S_FIN   = 3'd5
  } dma_state_e;

  localparam int unsigned ICB_AW = 32;
  localparam int unsigned ICB_DW = 32;
  localparam logic [3:0]  WMASK_FULL = 4'hF;

  // Byte address of word idx relative to a word-aligned base; wraps modulo 2^32.
  function automatic logic [ICB_AW-1:0] mem_word_addr(input logic [ICB_AW-1:0] base,
                                                      input logic [ICB_AW-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/icb_dma_master.sv
// Single-outstanding ICB initiator moving word blocks between system memory
// and local SRAM. Every output is a flop loaded from the next-state values,
// so the bus and SRAM see glitch-free strobes that line up with the state.
module icb_dma_master
  import dma_pkg::*;
#(
  parameter int SRAM_AW = 13,
  parameter int LEN_W   = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dir,
  input  logic [ICB_AW-1:0]   mem_base,
  input  logic [SRAM_AW-1:0]  sram_base,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                icb_cmd_valid,
  input  logic                icb_cmd_ready,
  output logic                icb_cmd_read,
  output logic [ICB_AW-1:0]   icb_cmd_addr,
  output logic [ICB_DW-1:0]   icb_cmd_wdata,
  output logic [3:0]          icb_cmd_wmask,
  input  logic                icb_rsp_valid,
  output logic                icb_rsp_ready,
  input  logic [ICB_DW-1:0]   icb_rsp_rdata,
  input  logic                icb_rsp_err,
  output logic                sram_rd_en,
  output logic [SRAM_AW-1:0]  sram_rd_addr,
  input  logic [ICB_DW-1:0]   sram_rd_data,
  output logic                sram_wr_en,
  output logic [SRAM_AW-1:0]  sram_wr_addr,
  output logic [ICB_DW-1:0]   sram_wr_data
);

  // Transfer context
  dma_state_e          state_q, state_d;
  logic                dir_q, dir_d;
  logic [ICB_AW-1:0]   mem_base_q, mem_base_d;
  logic [SRAM_AW-1:0]  sram_base_q, sram_base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [ICB_DW-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  // Output registers
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_read_q, cmd_read_d;
  logic [ICB_AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [ICB_DW-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [3:0]          cmd_wmask_q, cmd_wmask_d;
  logic                rsp_ready_q, rsp_ready_d;
  logic                rd_en_q, rd_en_d;
  logic [SRAM_AW-1:0]  rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [SRAM_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [ICB_DW-1:0]   wr_data_q, wr_data_d;

  // Next-state, context update and the SRAM write captured from a good read response.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    mem_base_d  = mem_base_q;
    sram_base_d = sram_base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = {SRAM_AW{1'b0}};
    wr_data_d   = {ICB_DW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d       = dir;
          mem_base_d  = mem_base & 32'hFFFF_FFFC;
          sram_base_d = sram_base;
          len_d       = len;
          err_d       = 1'b0;
          idx_d       = {LEN_W{1'b0}};
          if (len == {LEN_W{1'b0}}) begin
            state_d = S_FIN;
          end else if (dir) begin
            state_d = S_SRD;
          end else begin
            state_d = S_CMD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SRD: begin
        state_d = S_SWAIT;
      end
      S_SWAIT: begin
        wdata_d = sram_rd_data;
        state_d = S_CMD;
      end
      S_CMD: begin
        if (icb_cmd_ready) begin
          state_d = S_RSP;
        end else begin
          state_d = S_CMD;
        end
      end
      S_RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            if (!dir_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = sram_base_q + SRAM_AW'(idx_q);
              wr_data_d = icb_rsp_rdata;
            end else begin
              wr_en_d   = 1'b0;
            end
            if (idx_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1})) begin
              state_d = S_FIN;
            end else begin
              idx_d = idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
              if (dir_q) begin
                state_d = S_SRD;
              end else begin
                state_d = S_CMD;
              end
            end
          end
        end else begin
          state_d = S_RSP;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the state about to be entered; cmd fields hold while CMD waits.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    rsp_ready_d = (state_d == S_RSP);
    cmd_valid_d = 1'b0;
    cmd_read_d  = 1'b0;
    cmd_addr_d  = {ICB_AW{1'b0}};
    cmd_wdata_d = {ICB_DW{1'b0}};
    cmd_wmask_d = 4'h0;
    rd_en_d     = 1'b0;
    rd_addr_d   = {SRAM_AW{1'b0}};
    if (state_d == S_CMD) begin
      cmd_valid_d = 1'b1;
      cmd_read_d  = ~dir_d;
      cmd_addr_d  = mem_word_addr(mem_base_d, ICB_AW'(idx_d));
      cmd_wmask_d = WMASK_FULL;
      if (dir_d) begin
        cmd_wdata_d = wdata_d;
      end else begin
        cmd_wdata_d = {ICB_DW{1'b0}};
      end
    end else if (state_d == S_SRD) begin
      rd_en_d   = 1'b1;
      rd_addr_d = sram_base_d + SRAM_AW'(idx_d);
    end else begin
      rd_en_d   = 1'b0;
    end
  end

  // State, context and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      mem_base_q  <= {ICB_AW{1'b0}};
      sram_base_q <= {SRAM_AW{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      idx_q       <= {LEN_W{1'b0}};
      wdata_q     <= {ICB_DW{1'b0}};
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_addr_q  <= {ICB_AW{1'b0}};
      cmd_wdata_q <= {ICB_DW{1'b0}};
      cmd_wmask_q <= 4'h0;
      rsp_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {SRAM_AW{1'b0}};
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {SRAM_AW{1'b0}};
      wr_data_q   <= {ICB_DW{1'b0}};
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      mem_base_q  <= mem_base_d;
      sram_base_q <= sram_base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_read_q  <= cmd_read_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
      rsp_ready_q <= rsp_ready_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign icb_cmd_valid = cmd_valid_q;
  assign icb_cmd_read  = cmd_read_q;
  assign icb_cmd_addr  = cmd_addr_q;
  assign icb_cmd_wdata = cmd_wdata_q;
  assign icb_cmd_wmask = cmd_wmask_q;
  assign icb_rsp_ready = rsp_ready_q;
  assign sram_rd_en    = rd_en_q;
  assign sram_rd_addr  = rd_addr_q;
  assign sram_wr_en    = wr_en_q;
  assign sram_wr_addr  = wr_addr_q;
  assign sram_wr_data  = wr_data_q;

endmodule
